// File: rtl/grf_wb_arbiter.sv
// GRF write-port arbiter: merges zero-latency W-stage writes with queued mult/div results
// and tracks registers awaiting MD results. Optional write trace under `WBA_TRACE_EN`.
module grf_wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int AW           = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_we,
    input  logic [4:0]  wb_adr,
    input  logic [31:0] wb_wd,
    input  logic [31:0] wb_pc,
    input  logic        md_issue,
    input  logic [4:0]  md_issue_adr,
    output logic        md_issue_ok,
    input  logic        md_valid,
    input  logic [4:0]  md_adr,
    input  logic [31:0] md_wd,
    input  logic [31:0] md_pc,
    output logic        md_ready,
    output logic [31:0] pend,
    output logic        wb_hold,
    output logic        reg_we,
    output logic [4:0]  reg_adr3,
    output logic [31:0] reg_wd,
    output logic [31:0] WPC
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW:0]   CNT_ONE    = 1;
    localparam logic [AW:0]   CNT_FULL   = DEPTH[AW:0];
    localparam logic [AW-1:0] PTR_ONE    = 1;
    localparam logic [SW-1:0] STARVE_ONE = 1;
    localparam logic [SW-1:0] STARVE_MAX = STARVE_LIMIT[SW-1:0];

    logic [4:0]    adr_mem_q [DEPTH];
    logic [31:0]   wd_mem_q  [DEPTH];
    logic [31:0]   pc_mem_q  [DEPTH];

    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   pend_q, pend_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          hold_q, hold_d;

    logic empty, wb_sel, fifo_sel, push, store;

    always_comb begin
        empty       = (count_q == '0);
        wb_sel      = !reset && wb_we && (wb_adr != 5'd0) && !hold_q;
        fifo_sel    = !reset && !empty && (!wb_sel || hold_q);
        // Readiness comes from the registered count only, so a same-cycle pop never frees a slot early.
        md_ready    = !reset && (count_q < CNT_FULL);
        push        = md_valid && md_ready;
        store       = push && (md_adr != 5'd0);
        md_issue_ok = !reset && !pend_q[md_issue_adr];
        pend        = pend_q;
        wb_hold     = hold_q;

        reg_we   = 1'b0;
        reg_adr3 = 5'd0;
        reg_wd   = 32'd0;
        WPC      = 32'd0;
        if (wb_sel) begin
            reg_we   = 1'b1;
            reg_adr3 = wb_adr;
            reg_wd   = wb_wd;
            WPC      = wb_pc;
        end else if (fifo_sel) begin
            reg_we   = 1'b1;
            reg_adr3 = adr_mem_q[rptr_q];
            reg_wd   = wd_mem_q[rptr_q];
            WPC      = pc_mem_q[rptr_q];
        end
    end

    always_comb begin
        rptr_d  = fifo_sel ? rptr_q + PTR_ONE : rptr_q;
        wptr_d  = store ? wptr_q + PTR_ONE : wptr_q;
        count_d = count_q;
        case ({store, fifo_sel})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A new reservation wins over the clear from a retiring result to the same register.
        pend_d = pend_q;
        if (fifo_sel) pend_d[adr_mem_q[rptr_q]] = 1'b0;
        if (md_issue && (md_issue_adr != 5'd0)) pend_d[md_issue_adr] = 1'b1;
        pend_d[0] = 1'b0;

        starve_d = starve_q;
        if (empty || fifo_sel) begin
            starve_d = '0;
        end else if (wb_sel && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + STARVE_ONE;
        end

        hold_d = hold_q;
        if (fifo_sel) begin
            hold_d = 1'b0;
        end else if (starve_d >= STARVE_MAX) begin
            hold_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rptr_q   <= '0;
            wptr_q   <= '0;
            count_q  <= '0;
            pend_q   <= '0;
            starve_q <= '0;
            hold_q   <= 1'b0;
        end else begin
            rptr_q   <= rptr_d;
            wptr_q   <= wptr_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
            starve_q <= starve_d;
            hold_q   <= hold_d;
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            adr_mem_q[wptr_q] <= md_adr;
            wd_mem_q[wptr_q]  <= md_wd;
            pc_mem_q[wptr_q]  <= md_pc;
        end
    end

`ifdef WBA_TRACE_EN
    // This is the single print point for GRF writes; the GRF's own trace must be off.
    always @(posedge clk) begin
        if (reg_we && (reg_adr3 != 5'd0)) begin
            $display("@%h: $%d <= %h", WPC, reg_adr3, reg_wd);
        end
    end
`else
    // Trace disabled: no simulation output.
`endif

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Self-checking bench for grf_wb_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the write-port arbitration rules.
module tb_grf_wb_arbiter;

    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 8;

    logic        clk;
    logic        reset;
    logic        wb_we;
    logic [4:0]  wb_adr;
    logic [31:0] wb_wd;
    logic [31:0] wb_pc;
    logic        md_issue;
    logic [4:0]  md_issue_adr;
    logic        md_valid;
    logic [4:0]  md_adr;
    logic [31:0] md_wd;
    logic [31:0] md_pc;
    wire         md_issue_ok;
    wire         md_ready;
    wire  [31:0] pend;
    wire         wb_hold;
    wire         reg_we;
    wire  [4:0]  reg_adr3;
    wire  [31:0] reg_wd;
    wire  [31:0] WPC;

    grf_wb_arbiter #(.DEPTH(DEPTH), .AW(2), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .wb_we(wb_we), .wb_adr(wb_adr), .wb_wd(wb_wd), .wb_pc(wb_pc),
        .md_issue(md_issue), .md_issue_adr(md_issue_adr), .md_issue_ok(md_issue_ok),
        .md_valid(md_valid), .md_adr(md_adr), .md_wd(md_wd), .md_pc(md_pc),
        .md_ready(md_ready), .pend(pend), .wb_hold(wb_hold),
        .reg_we(reg_we), .reg_adr3(reg_adr3), .reg_wd(reg_wd), .WPC(WPC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  adr;
        logic [31:0] wd;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pend;
    int          m_starve;
    bit          m_hold;

    logic [104:0] exp_vec;
    wire  [104:0] act_vec = {reg_we, reg_adr3, reg_wd, WPC, md_ready, md_issue_ok, pend, wb_hold};

    int vectors;
    int miscompares;

    task automatic idle();
        wb_we = 0; wb_adr = 0; wb_wd = 0; wb_pc = 0;
        md_issue = 0; md_issue_adr = 0;
        md_valid = 0; md_adr = 0; md_wd = 0; md_pc = 0;
    endtask

    // Settle inputs and derive the expected output vector from the model.
    task automatic eval();
        logic        e_we, e_ready, e_ok;
        logic [4:0]  e_adr;
        logic [31:0] e_wd, e_pc;
        bit          w;
        #1;
        e_we = 0; e_adr = 0; e_wd = 0; e_pc = 0; e_ready = 0; e_ok = 0;
        if (!reset) begin
            w = wb_we && (wb_adr != 0) && !m_hold;
            if (w) begin
                e_we = 1; e_adr = wb_adr; e_wd = wb_wd; e_pc = wb_pc;
            end else if (mq.size() > 0) begin
                e_we = 1; e_adr = mq[0].adr; e_wd = mq[0].wd; e_pc = mq[0].pc;
            end
            e_ready = (mq.size() < DEPTH);
            e_ok    = !m_pend[md_issue_adr];
        end
        exp_vec = {e_we, e_adr, e_wd, e_pc, e_ready, e_ok, m_pend, m_hold};
    endtask

    // Advance one clock and apply the same inputs to the model.
    task automatic tick();
        int   n;
        bit   w, f;
        ent_t h;
        @(posedge clk);
        if (reset) begin
            mq.delete();
            m_pend = 0; m_starve = 0; m_hold = 0;
        end else begin
            n = mq.size();
            w = wb_we && (wb_adr != 0) && !m_hold;
            f = !w && (n > 0);
            if (f) begin
                h = mq.pop_front();
                m_pend[h.adr] = 1'b0;
            end
            if (md_valid && (n < DEPTH) && (md_adr != 0)) mq.push_back({md_adr, md_wd, md_pc});
            if (md_issue && (md_issue_adr != 0)) m_pend[md_issue_adr] = 1'b1;
            if (f || n == 0) m_starve = 0;
            else if (w) m_starve++;
            if (f) m_hold = 0;
            else if (m_starve >= STARVE_LIMIT) m_hold = 1;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1; idle();
        tick(); tick();
        eval();
        vectors++;
        if ({reg_we, md_ready, md_issue_ok} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_outputs act=%b exp=000", {reg_we, md_ready, md_issue_ok});
        end
        vectors++;
        if (act_vec !== exp_vec) begin miscompares++; $display("FAIL reset_model act=%h exp=%h", act_vec, exp_vec); end
        tick();
        reset = 0;
        eval();
        vectors++;
        if ({pend, wb_hold, md_ready, reg_we} !== {32'd0, 1'b0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_release act=%h/%b/%b/%b exp=0/0/1/0", pend, wb_hold, md_ready, reg_we);
        end
        tick();
    endtask

    task automatic test_wb_path();
        idle(); wb_we = 1; wb_adr = 5; wb_wd = 32'h1234; wb_pc = 32'h3000;
        eval();
        vectors++;
        if ({reg_we, reg_adr3, reg_wd, WPC} !== {1'b1, 5'd5, 32'h1234, 32'h3000}) begin
            miscompares++;
            $display("FAIL wb_write act=%b/%0d/%h/%h exp=1/5/1234/3000", reg_we, reg_adr3, reg_wd, WPC);
        end
        tick();
        wb_adr = 0;
        eval();
        vectors++;
        if (reg_we !== 1'b0) begin miscompares++; $display("FAIL wb_zero_adr act=%b exp=0", reg_we); end
        vectors++;
        if (act_vec !== exp_vec) begin miscompares++; $display("FAIL wb_model act=%h exp=%h", act_vec, exp_vec); end
        tick();
    endtask

    task automatic test_md_path();
        idle(); md_issue = 1; md_issue_adr = 8;
        eval();
        vectors++;
        if (act_vec !== exp_vec) begin miscompares++; $display("FAIL md_issue_model act=%h exp=%h", act_vec, exp_vec); end
        tick();
        idle(); md_issue_adr = 8;
        eval();
        vectors++;
        if ({pend[8], md_issue_ok} !== 2'b10) begin
            miscompares++;
            $display("FAIL md_pend_set act=%b%b exp=10", pend[8], md_issue_ok);
        end
        md_valid = 1; md_adr = 8; md_wd = 32'hDEAD; md_pc = 32'h4000;
        eval();
        vectors++;
        if (reg_we !== 1'b0) begin miscompares++; $display("FAIL md_no_bypass act=%b exp=0", reg_we); end
        tick();
        idle();
        eval();
        vectors++;
        if ({reg_we, reg_adr3, reg_wd, WPC, pend[8]} !== {1'b1, 5'd8, 32'hDEAD, 32'h4000, 1'b1}) begin
            miscompares++;
            $display("FAIL md_write act=%b/%0d/%h/%h/%b exp=1/8/dead/4000/1", reg_we, reg_adr3, reg_wd, WPC, pend[8]);
        end
        tick();
        eval();
        vectors++;
        if ({pend[8], reg_we} !== 2'b00) begin miscompares++; $display("FAIL md_pend_clear act=%b%b exp=00", pend[8], reg_we); end
        tick();
    endtask

    task automatic test_fill();
        bit sent;
        for (int i = 0; i < 5; i++) begin
            idle();
            wb_we = 1; wb_adr = 5'($urandom_range(1, 31)); wb_wd = $urandom; wb_pc = $urandom;
            md_valid = 1; md_adr = 5'(10 + i); md_wd = 32'hA000 + i; md_pc = 32'h6000 + 4 * i;
            eval();
            vectors++;
            if (act_vec !== exp_vec) begin miscompares++; $display("FAIL fill_model[%0d] act=%h exp=%h", i, act_vec, exp_vec); end
            if (i == 4) begin
                vectors++;
                if (md_ready !== 1'b0) begin miscompares++; $display("FAIL fill_full act=%b exp=0", md_ready); end
            end
            tick();
        end
        sent = 0;
        for (int i = 0; i < 5; i++) begin
            idle();
            if (!sent) begin md_valid = 1; md_adr = 14; md_wd = 32'hA004; md_pc = 32'h6010; end
            eval();
            vectors++;
            if ({reg_we, reg_adr3, reg_wd} !== {1'b1, 5'(10 + i), 32'hA000 + i}) begin
                miscompares++;
                $display("FAIL drain_order[%0d] act=%b/%0d/%h exp=1/%0d/%h", i, reg_we, reg_adr3, reg_wd, 10 + i, 32'hA000 + i);
            end
            vectors++;
            if (act_vec !== exp_vec) begin miscompares++; $display("FAIL drain_model[%0d] act=%h exp=%h", i, act_vec, exp_vec); end
            if (md_valid && mq.size() < DEPTH) sent = 1;
            tick();
        end
        idle();
        eval();
        vectors++;
        if (reg_we !== 1'b0) begin miscompares++; $display("FAIL drain_empty act=%b exp=0", reg_we); end
    endtask

    task automatic test_starve();
        for (int i = 0; i < 20; i++) begin
            idle();
            wb_we = !m_hold; wb_adr = 5'($urandom_range(1, 31)); wb_wd = $urandom; wb_pc = $urandom;
            if (i == 0) begin md_valid = 1; md_adr = 20; md_wd = 32'h5555_0014; md_pc = 32'h5000; end
            eval();
            vectors++;
            if (wb_hold !== (i == 9)) begin miscompares++; $display("FAIL starve_hold[%0d] act=%b exp=%b", i, wb_hold, i == 9); end
            if (i == 9) begin
                vectors++;
                if ({reg_we, reg_adr3, reg_wd} !== {1'b1, 5'd20, 32'h5555_0014}) begin
                    miscompares++;
                    $display("FAIL starve_pop act=%b/%0d/%h exp=1/20/55550014", reg_we, reg_adr3, reg_wd);
                end
            end
            vectors++;
            if (act_vec !== exp_vec) begin miscompares++; $display("FAIL starve_model[%0d] act=%h exp=%h", i, act_vec, exp_vec); end
            tick();
        end
    endtask

    task automatic test_same_cycle();
        idle(); md_issue = 1; md_issue_adr = 9;
        eval(); tick();
        idle(); md_valid = 1; md_adr = 9; md_wd = 32'h99; md_pc = 32'h7000;
        eval();
        vectors++;
        if (act_vec !== exp_vec) begin miscompares++; $display("FAIL same_push_model act=%h exp=%h", act_vec, exp_vec); end
        tick();
        idle(); md_issue = 1; md_issue_adr = 9;
        eval();
        vectors++;
        if ({reg_we, reg_adr3} !== {1'b1, 5'd9}) begin
            miscompares++;
            $display("FAIL same_pop act=%b/%0d exp=1/9", reg_we, reg_adr3);
        end
        tick();
        idle();
        eval();
        vectors++;
        if (pend[9] !== 1'b1) begin miscompares++; $display("FAIL same_cycle_pend act=%b exp=1", pend[9]); end
        tick();
    endtask

    task automatic test_zero_push();
        for (int i = 0; i < 6; i++) begin
            idle(); md_valid = 1; md_adr = 0; md_wd = $urandom; md_pc = $urandom;
            eval();
            vectors++;
            if ({md_ready, reg_we} !== 2'b10) begin
                miscompares++;
                $display("FAIL zero_push[%0d] act=%b%b exp=10", i, md_ready, reg_we);
            end
            tick();
        end
        idle();
        eval();
        vectors++;
        if (act_vec !== exp_vec) begin miscompares++; $display("FAIL zero_push_model act=%h exp=%h", act_vec, exp_vec); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            idle(); wb_we = 1; wb_adr = 1; wb_wd = $urandom;
            md_issue = 1; md_issue_adr = 5'(8 + i);
            md_valid = 1; md_adr = 5'(8 + i); md_wd = $urandom; md_pc = $urandom;
            eval(); tick();
        end
        idle(); wb_we = 1; wb_adr = 1;
        eval();
        vectors++;
        if (pend !== 32'h0000_0700) begin miscompares++; $display("FAIL mid_pend act=%h exp=00000700", pend); end
        reset = 1;
        eval();
        vectors++;
        if (act_vec !== exp_vec) begin miscompares++; $display("FAIL mid_reset_model act=%h exp=%h", act_vec, exp_vec); end
        tick();
        reset = 0; idle();
        eval();
        vectors++;
        if ({pend, reg_we, wb_hold, md_ready} !== {32'd0, 1'b0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL mid_after act=%h/%b/%b/%b exp=0/0/0/1", pend, reg_we, wb_hold, md_ready);
        end
        tick();
        eval();
        vectors++;
        if (reg_we !== 1'b0) begin miscompares++; $display("FAIL mid_discard act=%b exp=0", reg_we); end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            wb_we = ($urandom_range(0, 9) < 7); wb_adr = 5'($urandom_range(0, 31));
            wb_wd = $urandom; wb_pc = $urandom;
            md_issue = ($urandom_range(0, 3) == 0); md_issue_adr = 5'($urandom_range(0, 31));
            md_valid = ($urandom_range(0, 2) == 0); md_adr = 5'($urandom_range(0, 31));
            md_wd = $urandom; md_pc = $urandom;
            eval();
            vectors++;
            if (act_vec !== exp_vec) begin miscompares++; $display("FAIL random[%0d] act=%h exp=%h", i, act_vec, exp_vec); end
            tick();
        end
        reset = 0;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        m_pend = 0; m_starve = 0; m_hold = 0;
        test_reset();
        test_wb_path();
        test_md_path();
        test_fill();
        test_starve();
        test_same_cycle();
        test_zero_push();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
